muldiv_unit: RTL and testbench
==============================

# muldiv_unit

Iterative sequencer for the RV32M multiply/divide instructions, in the execute stage beside the single-cycle ALU. On a start request it captures both operands and runs a 32-iteration shift-add multiply or restoring divide, then applies sign correction. It holds the pipeline with a stall output until the result is ready. Division by zero and signed overflow complete on a fast path.

## Interface
- XLEN, 32, operand/result width; only 32 is supported.
- clk  input  1  clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  request; sampled only in IDLE.
- funct3  input  3  op: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- SrcA  input  32  rs1 operand (multiplicand/dividend).
- SrcB  input  32  rs2 operand (multiplier/divisor).
- flush  input  1  abort the current operation (branch mispredict/trap).
- Result  output  32  registered result; holds until the next accepted start.
- done  output  1  one-cycle pulse; Result is valid.
- busy  output  1  high in CALC and FIXUP.
- Stall  output  1  combinational: (IDLE & start & ~flush) | CALC | FIXUP.

## Operation
- **States:** IDLE, CALC, FIXUP, DONE. Encoding is free.
- **IDLE, start=1, flush=0:** latch funct3 and the operand magnitudes.
  - Absolute value for signed operands. MULHSU treats SrcA as signed and SrcB as unsigned.
  - Record the result sign. Product/quotient: signA ^ signB. Remainder: signA.
  - Clear the 6-bit iteration counter, then go to CALC.
- **Fast path (IDLE → DONE directly):**
  - Divide op with SrcB == 0. DIV/DIVU return 0xFFFFFFFF; REM/REMU return SrcA.
  - DIV/REM with SrcA == 0x80000000 and SrcB == 0xFFFFFFFF. DIV returns 0x80000000; REM returns 0.
- **CALC, multiply:** 64-bit accumulator. Each cycle, if multiplier bit0 = 1, add the multiplicand into the upper half. Then shift right 1 (33-bit carry kept).
- **CALC, divide:** restoring. Each cycle, shift {rem, quot} left 1 and trial-subtract the divisor from rem. If the result is non-negative, keep it and set quot bit0.
- **Leaving CALC:** after 32 iterations (counter == 31), go to FIXUP.
- **FIXUP:** two's-complement negate if the recorded sign is 1. Width is 64 bits for multiply, 32 for the quotient/remainder. Select the output:
  - MUL: low 32 bits.
  - MULH/MULHSU/MULHU: high 32 bits.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Register it into Result and go to DONE.
- **DONE:** done=1 for exactly one cycle, then IDLE. A start in DONE is ignored. The pipeline has advanced and presents the next op in IDLE.
- **start while busy:** ignored. Operands and funct3 stay as latched.
- **flush:** from any state, next state is IDLE, counter cleared, no done pulse, Result unchanged. flush has priority over start in the same cycle.
- **reset:** overrides everything, including mid-operation.
  - State IDLE, counter 0.
  - Result = 0, done = 0, busy = 0, Stall = 0 (unless start is high in IDLE).
  - All internal registers cleared.

## Timing
- Cycle 0 is the cycle in which start is sampled in IDLE.
- **Normal ops:** CALC during cycles 1–32, FIXUP in cycle 33, DONE in cycle 34 (done=1, Stall=0). Accept-to-result latency is 34 cycles. The next start can be accepted in cycle 35.
- **Fast path:** DONE in cycle 1. Stall is high in cycle 0 only.
- **Stall:** high in cycles 0–33 of a normal op. It drops in the same cycle done rises, so the stalled instruction advances with Result.
- **Result:** changes only on the FIXUP→DONE edge or the fast-path edge.

## Test plan
- MUL 7 × 0xFFFFFFFD (−3) → Result 0xFFFFFFEB. done only in cycle 34; Stall high in cycles 0–33.
- Upper-half multiplies → high-half results:
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
- Signed divide/remainder:
  - DIV 0xFFFFFFF9 (−7) / 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
- Special cases, each with done in cycle 1:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REM 5/0 → 5.
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM same operands → 0.
- Interruptions:
  - flush in cycle 10 of a MUL → IDLE in cycle 11, no done pulse, Result keeps its prior value. A new start in cycle 11 completes normally.
  - Asserting start during CALC has no effect.
- reset in cycle 20 of a DIV → cycle 21: IDLE, Result 0, busy 0, done 0. A back-to-back MUL 3×4 then yields 12.

Source files
------------

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide sequencer: 32-step shift-add multiply or restoring
// divide with sign fix-up, plus a one-cycle path for divide-by-zero and signed overflow.
module muldiv_unit #(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] SrcA,
  input  logic [XLEN-1:0] SrcB,
  input  logic            flush,
  output logic [XLEN-1:0] Result,
  output logic            done,
  output logic            busy,
  output logic            Stall
);
  localparam int unsigned CntW = 6;
  localparam int unsigned AccW = 2 * XLEN;
  localparam logic [XLEN-1:0] MinNeg = {1'b1, {(XLEN-1){1'b0}}};
  localparam logic [CntW-1:0] LastIter = CntW'(XLEN - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIXUP, S_DONE} state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [2:0]      op_q;
  logic            neg_q;
  logic [XLEN-1:0] opnd_q;    // multiplicand or divisor magnitude
  logic [AccW-1:0] acc_q;     // {hi, lo} product, or {rem, quot} for divide
  logic [XLEN-1:0] result_q;
  logic            done_q;
  logic            busy_q;

  // Operand decode at accept time
  logic            a_signed, b_signed, sign_a, sign_b, res_neg, is_fast, is_mul;
  logic [XLEN-1:0] abs_a, abs_b, fast_res;

  always_comb begin
    a_signed = !(funct3 inside {3'b011, 3'b101, 3'b111});
    b_signed = a_signed && (funct3 != 3'b010);
    sign_a   = a_signed && SrcA[XLEN-1];
    sign_b   = b_signed && SrcB[XLEN-1];
    abs_a    = sign_a ? XLEN'(-SrcA) : SrcA;
    abs_b    = sign_b ? XLEN'(-SrcB) : SrcB;
    res_neg  = (funct3 == 3'b110) ? sign_a : (sign_a ^ sign_b);
    is_mul   = !funct3[2];
    is_fast  = 1'b0;
    fast_res = '0;
    if (funct3[2]) begin
      if (SrcB == '0) begin
        is_fast  = 1'b1;
        fast_res = funct3[1] ? SrcA : '1;
      end else if (!funct3[0] && (SrcA == MinNeg) && (SrcB == '1)) begin
        is_fast  = 1'b1;
        fast_res = funct3[1] ? '0 : MinNeg;
      end
    end
  end

  // One iteration of shift-add multiply or restoring divide
  logic [XLEN:0]   mul_sum, div_shift, div_diff;
  logic [AccW-1:0] acc_step;

  always_comb begin
    mul_sum = {1'b0, acc_q[AccW-1:XLEN]};
    if (acc_q[0]) mul_sum = mul_sum + {1'b0, opnd_q};
    div_shift = acc_q[AccW-1:XLEN-1];
    div_diff  = div_shift - {1'b0, opnd_q};
    if (op_q[2]) begin
      if (div_diff[XLEN]) acc_step = {div_shift[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
      else                acc_step = {div_diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
    end else begin
      acc_step = {mul_sum, acc_q[XLEN-1:1]};
    end
  end

  // Sign correction and result select
  logic [AccW-1:0] prod;
  logic [XLEN-1:0] quot, rem, fix_res;

  always_comb begin
    prod = neg_q ? AccW'(-acc_q) : acc_q;
    quot = neg_q ? XLEN'(-acc_q[XLEN-1:0]) : acc_q[XLEN-1:0];
    rem  = neg_q ? XLEN'(-acc_q[AccW-1:XLEN]) : acc_q[AccW-1:XLEN];
    if (op_q[2])                fix_res = op_q[1] ? rem : quot;
    else if (op_q[1:0] == 2'b00) fix_res = prod[XLEN-1:0];
    else                        fix_res = prod[AccW-1:XLEN];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      opnd_q   <= '0;
      acc_q    <= '0;
      result_q <= '0;
      done_q   <= 1'b0;
      busy_q   <= 1'b0;
    end else if (flush) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q  <= funct3;
            neg_q <= res_neg;
            cnt_q <= '0;
            if (is_fast) begin
              result_q <= fast_res;
              done_q   <= 1'b1;
              state_q  <= S_DONE;
            end else begin
              opnd_q  <= is_mul ? abs_a : abs_b;
              acc_q   <= {{XLEN{1'b0}}, (is_mul ? abs_b : abs_a)};
              busy_q  <= 1'b1;
              state_q <= S_CALC;
            end
          end
        end
        S_CALC: begin
          acc_q <= acc_step;
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == LastIter) state_q <= S_FIXUP;
        end
        S_FIXUP: begin
          result_q <= fix_res;
          busy_q   <= 1'b0;
          done_q   <= 1'b1;
          state_q  <= S_DONE;
        end
        S_DONE: begin
          done_q  <= 1'b0;
          state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign Result = result_q;
  assign done   = done_q;
  assign busy   = busy_q;
  assign Stall  = ((state_q == S_IDLE) && start && !flush) ||
                  (state_q == S_CALC) || (state_q == S_FIXUP);

endmodule

// File: tb/tb_muldiv_unit.sv
// Scoreboard bench for muldiv_unit: directed RV32M cases, flush/reset interruptions and
// randomized ops checked against a plain-arithmetic reference model.
module tb_muldiv_unit;
  logic        clk = 1'b0;
  logic        reset, start, flush, done, busy, Stall;
  logic [2:0]  funct3;
  logic [31:0] SrcA, SrcB, Result;

  muldiv_unit dut (
    .clk(clk), .reset(reset), .start(start), .funct3(funct3), .SrcA(SrcA), .SrcB(SrcB),
    .flush(flush), .Result(Result), .done(done), .busy(busy), .Stall(Stall)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    int unsigned cyc;
  } exp_t;

  exp_t        sb_q[$];
  int unsigned cyc = 0;
  int          n_total = 0;
  int          n_pass = 0;
  logic [31:0] last_res = 32'h0;
  logic [31:0] corners[5] = '{32'h0, 32'h1, 32'hFFFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF};

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
  endfunction

  function automatic bit is_fast(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    return f3[2] && ((b == 32'h0) || (!f3[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF));
  endfunction

  // Reference results straight from the RV32M definitions using 64-bit arithmetic
  function automatic logic [31:0] ref_result(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    longint          sa, sb, p;
    longint unsigned ua, ub, up;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'h0, a};
    ub = {32'h0, b};
    case (f3)
      3'b000: begin p = sa * sb; return p[31:0]; end
      3'b001: begin p = sa * sb; return p[63:32]; end
      3'b010: begin p = sa * longint'(ub); return p[63:32]; end
      3'b011: begin up = ua * ub; return up[63:32]; end
      3'b100: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h8000_0000;
        p = sa / sb; return p[31:0];
      end
      3'b101: begin
        if (b == 32'h0) return 32'hFFFF_FFFF;
        up = ua / ub; return up[31:0];
      end
      3'b110: begin
        if (b == 32'h0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'h0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 32'h0) return a;
        up = ua % ub; return up[31:0];
      end
    endcase
  endfunction

  // Monitor: every done pulse must match the oldest expected entry, on time
  always @(negedge clk) begin
    exp_t e;
    if (done === 1'b1) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $display("FAIL spurious_done: got done=1 expected no pending op (cycle %0d)", cyc);
      end else begin
        e = sb_q.pop_front();
        check("result", Result, e.res);
        check("done_cycle", cyc, e.cyc);
      end
    end else if (sb_q.size() > 0 && cyc > sb_q[0].cyc) begin
      e = sb_q.pop_front();
      n_total++;
      $display("FAIL done_timeout: got no done by cycle %0d expected done at %0d", cyc, e.cyc);
    end
  end

  // Called just after a rising edge; returns in the done cycle after its falling edge
  task automatic run_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    int   lat;
    exp_t e;
    lat = is_fast(f3, a, b) ? 1 : 34;
    start = 1'b1; funct3 = f3; SrcA = a; SrcB = b;
    e.res = ref_result(f3, a, b);
    e.cyc = cyc + 32'(lat);
    sb_q.push_back(e);
    for (int n = 0; n <= lat; n++) begin
      @(negedge clk);
      check("stall", 32'(Stall), 32'(n < lat));
      check("busy", 32'(busy), 32'(n >= 1 && n < lat));
      if (n < lat) check("result_hold", Result, last_res);
      if (n == lat) start = 1'b0;
      else if (n >= 1) begin
        // junk on the inputs while busy must not disturb the latched op
        start  = 1'($urandom_range(0, 1));
        funct3 = 3'($urandom);
        SrcA   = $urandom;
        SrcB   = $urandom;
      end
    end
    last_res = e.res;
  endtask

  task automatic op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    run_op(f3, a, b);
    @(posedge clk); #1;
  endtask

  // Start a normal op and kill it with flush or reset sampled at the end of cycle 'at'
  task automatic abort_op(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b,
                          input int at, input bit use_reset);
    start = 1'b1; funct3 = f3; SrcA = a; SrcB = b;
    for (int n = 0; n <= at; n++) begin
      @(negedge clk);
      check("abort_stall", 32'(Stall), 32'h1);
      check("abort_busy", 32'(busy), 32'(n >= 1));
      check("abort_result_hold", Result, last_res);
      if (n == 1) start = 1'b0;
      if (n == at) begin
        if (use_reset) reset = 1'b1;
        else flush = 1'b1;
      end
    end
    @(posedge clk); #1;
    reset = 1'b0;
    flush = 1'b0;
    if (use_reset) last_res = 32'h0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish by %0t expected completion", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [2:0]  f3;
    logic [31:0] a, b;
    reset = 1'b1; start = 1'b0; flush = 1'b0; funct3 = 3'h0; SrcA = 32'h0; SrcB = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("reset_result", Result, 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_busy", 32'(busy), 32'h0);
    check("reset_stall", 32'(Stall), 32'h0);
    @(posedge clk); #1;

    op(3'b000, 32'h0000_0007, 32'hFFFF_FFFD);
    op(3'b001, 32'h8000_0000, 32'h8000_0000);
    op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    op(3'b100, 32'hFFFF_FFF9, 32'h0000_0002);
    op(3'b110, 32'hFFFF_FFF9, 32'h0000_0002);
    op(3'b101, 32'hFFFF_FFF9, 32'h0000_0002);
    op(3'b101, 32'h0000_0005, 32'h0000_0000);
    op(3'b110, 32'h0000_0005, 32'h0000_0000);
    op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF);
    op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF);

    op(3'b000, 32'h0000_1234, 32'h0000_0010);
    abort_op(3'b000, 32'h0000_0005, 32'h0000_0006, 10, 1'b0);
    op(3'b000, 32'h0000_0009, 32'h0000_0009);

    abort_op(3'b100, 32'h0000_0064, 32'h0000_0007, 20, 1'b1);
    op(3'b000, 32'h0000_0003, 32'h0000_0004);

    for (int i = 0; i < 40; i++) begin
      f3 = 3'($urandom);
      a  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      b  = ($urandom_range(0, 3) == 0) ? corners[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 3) == 0) b = b >> $urandom_range(1, 31);
      op(f3, a, b);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
